// File: rtl/ifetch_queue_if.sv
// -----------------------------------------------------------------------------
// ifetch_queue_if
//   Bundles the instruction-fetch front-end's bus signals: the ROM read port,
//   the redirect (branch/jump) request and the decode-side valid/ready port.
//
//   Signals (direction as seen by the fetch queue, i.e. the slave modport):
//     fetch_en        in   allow new ROM reads
//     rom_rd          out  ROM read strobe
//     rom_raddr       out  ROM read address
//     rom_rdata       in   ROM data, valid the cycle after rom_rd
//     redirect_valid  in   flush request (one-cycle pulse)
//     redirect_pc     in   restart PC, sampled with redirect_valid
//     dec_valid       out  head entry valid
//     dec_ready       in   decode accepts head entry
//     dec_instr       out  head instruction
//     dec_pc          out  PC of head instruction
//     q_count         out  occupied queue entries
//
//   master: the environment around the queue (ROM + decode + branch unit)
//   slave : the fetch queue itself
// -----------------------------------------------------------------------------
interface ifetch_queue_if #(
   parameter int ROM_AWIDTH = 8,
   parameter int IWIDTH     = 16,
   parameter int DEPTH      = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                  fetch_en;
   logic                  rom_rd;
   logic [ROM_AWIDTH-1:0] rom_raddr;
   logic [IWIDTH-1:0]     rom_rdata;
   logic                  redirect_valid;
   logic [ROM_AWIDTH-1:0] redirect_pc;
   logic                  dec_valid;
   logic                  dec_ready;
   logic [IWIDTH-1:0]     dec_instr;
   logic [ROM_AWIDTH-1:0] dec_pc;
   logic [CNT_W-1:0]      q_count;

   modport master (
      output fetch_en, rom_rdata, redirect_valid, redirect_pc, dec_ready,
      input  rom_rd, rom_raddr, dec_valid, dec_instr, dec_pc, q_count
   );

   modport slave (
      input  fetch_en, rom_rdata, redirect_valid, redirect_pc, dec_ready,
      output rom_rd, rom_raddr, dec_valid, dec_instr, dec_pc, q_count
   );
endinterface

// File: rtl/ifetch_queue.sv
// -----------------------------------------------------------------------------
// ifetch_queue
//   Instruction fetch front-end. Owns the fetch PC, issues sequential reads to
//   a ROM with one cycle of read latency, buffers returned instructions tagged
//   with their PC in a small FIFO and hands them to decode over valid/ready.
//   A redirect flushes the queue and restarts fetch at a new PC.
//
//   Ports:
//     clk      system clock, rising edge
//     ext_rst  asynchronous active-low reset
//     bus      ifetch_queue_if slave modport (ROM port, redirect, decode port,
//              fetch_en, q_count)
// -----------------------------------------------------------------------------
module ifetch_queue #(
   parameter int ROM_AWIDTH = 8,
   parameter int IWIDTH     = 16,
   parameter int DEPTH      = 4,
   parameter int PC_STEP    = 2,
   parameter int RESET_PC   = 0
) (
   input  logic           clk,
   input  logic           ext_rst,
   ifetch_queue_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Fetch side state
   logic [ROM_AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic                  pend_q, pend_d;
   logic [ROM_AWIDTH-1:0] pend_pc_q, pend_pc_d;
   logic                  drop_q, drop_d;

   // Queue state
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [ROM_AWIDTH-1:0] mem_pc_q    [DEPTH];
   logic [IWIDTH-1:0]     mem_instr_q [DEPTH];

   logic                  redirect;
   logic                  issue;
   logic                  push;
   logic                  pop;
   logic                  not_empty;
   logic [CNT_W:0]        committed;

   assign redirect  = bus.redirect_valid;
   assign not_empty = (count_q != '0);

   // Credit counts both stored entries and the read already in flight, using
   // only registered occupancy so a push can never land on a full queue.
   assign committed = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};

   // ext_rst gates the strobe so the ROM sees no read while reset is held.
   assign issue = ext_rst & bus.fetch_en & ~redirect &
                  (committed < (CNT_W+1)'(DEPTH));

   // A response landing in a redirect cycle belongs to the old stream.
   assign push = pend_q & ~drop_q & ~redirect;
   assign pop  = not_empty & bus.dec_ready & ~redirect;

   assign bus.rom_rd    = issue;
   assign bus.rom_raddr = fetch_pc_q;
   assign bus.dec_valid = not_empty;
   assign bus.dec_instr = not_empty ? mem_instr_q[rd_ptr_q] : '0;
   assign bus.dec_pc    = not_empty ? mem_pc_q[rd_ptr_q]    : '0;
   assign bus.q_count   = count_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      pend_d     = issue;
      pend_pc_d  = pend_pc_q;
      drop_d     = drop_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (redirect) begin
         fetch_pc_d = bus.redirect_pc;
         drop_d     = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (issue) begin
            // Natural truncation gives the modulo-2^ROM_AWIDTH PC wrap.
            fetch_pc_d = fetch_pc_q + ROM_AWIDTH'(PC_STEP);
            pend_pc_d  = fetch_pc_q;
         end
         // DEPTH is a power of two, so pointer overflow is the FIFO wrap.
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge ext_rst) begin
      if (!ext_rst) begin
         fetch_pc_q <= ROM_AWIDTH'(RESET_PC);
         pend_q     <= 1'b0;
         drop_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
         drop_q     <= drop_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Data storage carries no reset: it is only observed through pend_q and
   // count_q, both of which are reset.
   always_ff @(posedge clk) begin
      pend_pc_q <= pend_pc_d;
      if (push) begin
         mem_pc_q[wr_ptr_q]    <= pend_pc_q;
         mem_instr_q[wr_ptr_q] <= bus.rom_rdata;
      end
   end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front-end between the instruction ROM and the control/decode stage.
- Owns the fetch PC and issues sequential ROM reads. The ROM has a 1-cycle synchronous read latency.
- Buffers returned instructions, each tagged with its PC, in a small FIFO.
- Presents them to decode over a valid/ready handshake. A redirect input for taken branches and jumps flushes the queue and restarts fetch at a new PC.

Parameters:
- ROM_AWIDTH, 8, width of the PC and of the ROM address.
- IWIDTH, 16, instruction width.
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- PC_STEP, 2, sequential PC increment.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- ext_rst  in  1  asynchronous, active-low reset.
- fetch_en  in  1  1 = ROM reads may be issued; 0 = fetch holds, queue still drains.
- rom_rd  out  1  ROM read strobe.
- rom_raddr  out  ROM_AWIDTH  ROM read address.
- rom_rdata  in  IWIDTH  ROM data; valid in the cycle after rom_rd=1.
- redirect_valid  in  1  flush request, one-cycle pulse.
- redirect_pc  in  ROM_AWIDTH  new fetch PC, sampled when redirect_valid=1.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  decode accepts the head entry.
- dec_instr  out  IWIDTH  head instruction.
- dec_pc  out  ROM_AWIDTH  PC of the head instruction.
- q_count  out  clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (ext_rst=0, asynchronous):
  - fetch_pc=RESET_PC; FIFO pointers and q_count=0; pend=0; drop=0.
  - Outputs: rom_rd=0, dec_valid=0, dec_instr=0, dec_pc=0.
  - Reset mid-operation discards all queued and in-flight data. The first ROM read is RESET_PC in the first cycle after release (when fetch_en=1).
- Internal state:
  - fetch_pc: next address to read.
  - pend: a ROM response arrives this cycle.
  - pend_pc: PC of that response.
  - drop: discard that response.
  - FIFO of {pc, instr}.
- Issue rule (combinational): rom_rd = fetch_en & !redirect_valid & (q_count + pend < DEPTH); rom_raddr = fetch_pc.
  - Uses registered q_count only; a same-cycle pop does not grant credit.
  - This guarantees a push never meets a full FIFO.
- On issue:
  - fetch_pc <= fetch_pc + PC_STEP, mod 2^ROM_AWIDTH (wraps 0xFE -> 0x00 for defaults).
  - pend <= 1; pend_pc <= fetch_pc.
  - Otherwise pend <= 0.
- Push: when pend=1 and drop=0, write {pend_pc, rom_rdata} at the tail. Data is taken from the ROM in that same cycle.
- Pop: when dec_valid & dec_ready.
  - dec_valid = (q_count != 0); dec_instr/dec_pc = head entry, read combinationally.
  - Outputs read 0 when the FIFO is empty.
- Simultaneous push and pop: q_count is unchanged and both pointers advance. Pop from empty is ignored.
- Redirect (redirect_valid=1 in cycle N):
  - At the end of N: FIFO cleared (q_count=0), fetch_pc <= redirect_pc.
  - A response arriving in N is not pushed. A read issued in N-1 returns in N and is discarded.
  - drop <= 0; no read is issued in N.
  - Cycle N+1: rom_rd=1 at redirect_pc. Cycle N+2: data pushed. Cycle N+3: dec_valid=1, dec_pc=redirect_pc. Redirect-to-valid latency is 3 cycles.
  - Redirect has priority over push, pop and issue in the same cycle.
  - Back-to-back redirects: the last one wins.
- Steady state with dec_ready=1: one instruction per cycle after the initial 2-cycle fill.
- Wrap-around: FIFO pointers wrap modulo DEPTH; the fetch PC wraps modulo 2^ROM_AWIDTH.
- Invariants: q_count never exceeds DEPTH; PCs leave in strictly sequential order between redirects.

Test Plan:
- Reset release, fetch_en=1, dec_ready=1, ROM[a]=0x1000+a:
  - rom_raddr sequence 0,2,4,...
  - dec_valid first high 2 cycles after release.
  - Then (dec_pc, dec_instr) = (0,0x1000), (2,0x1002), ... one per cycle.
- dec_ready=0 held:
  - Exactly 4 entries queued (q_count=4); rom_rd low afterwards.
  - Release dec_ready: PCs 0,2,4,6,8 in order, with no gap or duplicate.
- Redirect to 0x40 while q_count=3 and a read is in flight:
  - q_count=0 next cycle; stale response not pushed.
  - rom_raddr=0x40 one cycle after the redirect.
  - dec_valid with dec_pc=0x40 three cycles after the redirect.
  - No old PC is ever output after the redirect.
- Redirect together with dec_ready=1 and a pending push in the same cycle: redirect wins; no entry emitted from the old stream.
- redirect_pc=0xFC, ready=1: output PCs 0xFC, 0xFE, 0x00, 0x02.
- ext_rst asserted mid-stream with q_count=2:
  - All outputs 0 immediately (asynchronous).
  - After release, fetch restarts at 0.
- fetch_en=0 with 2 entries queued: both drain; rom_rd stays 0; dec_valid falls to 0.
